// File: rtl/gpa_fhdo_dac_iface_pkg.sv
// Shared definitions for the GPA-FHDO DAC80504 SPI interface: FSM states,
// data word field positions and DAC80504 register addresses.
package gpa_fhdo_dac_iface_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    localparam int FRAME_BITS = 24;

    localparam int CH_MSB    = 26;
    localparam int CH_LSB    = 25;
    localparam int LAST_BIT  = 24;
    localparam int FRAME_MSB = 23;

    localparam logic [7:0] REG_NOP    = 8'h00;
    localparam logic [7:0] REG_CONFIG = 8'h03;
    localparam logic [7:0] REG_GAIN   = 8'h04;
    localparam logic [7:0] REG_DAC0   = 8'h08;
    localparam logic [7:0] REG_DAC1   = 8'h09;
    localparam logic [7:0] REG_DAC2   = 8'h0A;
    localparam logic [7:0] REG_DAC3   = 8'h0B;

    // CS# is asserted in every state that belongs to an active frame.
    function automatic logic frame_active(input state_e s);
        return (s == ST_LEAD) || (s == ST_SHIFT);
    endfunction

endpackage

// File: rtl/gpa_fhdo_spi_clkdiv.sv
// Half-period tick generator: tick_o pulses once every (div+1) clk cycles,
// restarting from a freshly latched divider whenever start_i is asserted.
module gpa_fhdo_spi_clkdiv (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [5:0] div_i,
    output logic       tick_o
);

    logic [5:0] div_q, div_d;
    logic [5:0] cnt_q, cnt_d;

    always_comb begin
        div_d = div_q;
        cnt_d = cnt_q;
        if (start_i) begin
            div_d = div_i;
            cnt_d = div_i;
        end else if (cnt_q == 6'd0) begin
            cnt_d = div_q;
        end else begin
            cnt_d = cnt_q - 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 6'd0;
            cnt_q <= 6'd0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == 6'd0);

endmodule

// File: rtl/gpa_fhdo_dac_iface.sv
// SPI master for the DAC80504 on the GPA-FHDO board: sends the low 24 bits of
// each sequencer word MSB-first with SCLK idling high and registered pins.
module gpa_fhdo_dac_iface
    import gpa_fhdo_dac_iface_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    input  logic [5:0]  spi_clk_div_i,
    output logic        busy_o,
    output logic        fhd_clk_o,
    output logic        fhd_sdo_o,
    output logic        fhd_csn_o,
    input  logic        fhd_sdi_i
);

    localparam logic [4:0] LAST_IDX = 5'(FRAME_BITS - 1);

    state_e      state_q, state_d;
    logic [23:0] shreg_q, shreg_d;
    logic [4:0]  bit_q, bit_d;
    logic        phase_q, phase_d;
    logic        csn_q, csn_d;
    logic        sclk_q, sclk_d;
    logic        sdo_q, sdo_d;
    logic        start;
    logic        tick;

    // Grouping fields and readback are owned by upstream logic / future revisions.
    logic unused_ok;
    assign unused_ok = ^{data_i[31:FRAME_MSB+1], fhd_sdi_i};

    gpa_fhdo_spi_clkdiv u_clkdiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .div_i   (spi_clk_div_i),
        .tick_o  (tick)
    );

    // phase_q: in SHIFT, 0 = SCLK low half, 1 = SCLK high half; in GAP, half index.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    start   = 1'b1;
                    state_d = ST_LEAD;
                    shreg_d = data_i[FRAME_MSB:0];
                    bit_d   = 5'd0;
                    phase_d = 1'b0;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                    phase_d = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        if (bit_q != LAST_IDX) begin
                            shreg_d = {shreg_q[22:0], 1'b0};
                        end
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == LAST_IDX) begin
                            state_d = ST_GAP;
                        end else begin
                            bit_d = bit_q + 5'd1;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        phase_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        csn_d  = !frame_active(state_d);
        sclk_d = !((state_d == ST_SHIFT) && !phase_d);
        sdo_d  = frame_active(state_d) ? shreg_d[23] : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bit_q   <= 5'd0;
            phase_q <= 1'b0;
            csn_q   <= 1'b1;
            sclk_q  <= 1'b1;
            sdo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            csn_q   <= csn_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
        end
    end

    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign fhd_csn_o = csn_q;
    assign fhd_clk_o = sclk_q;
    assign fhd_sdo_o = sdo_q;

endmodule

// File: tb/tb_gpa_fhdo_dac_iface.sv
// Directed bench for gpa_fhdo_dac_iface with a behavioural DAC80504 receiver.
module tb_gpa_fhdo_dac_iface;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic [5:0]  spi_clk_div_i = '0;
    logic        busy_o, fhd_clk_o, fhd_sdo_o, fhd_csn_o;
    logic        fhd_sdi_i = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    gpa_fhdo_dac_iface dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .spi_clk_div_i (spi_clk_div_i),
        .busy_o        (busy_o),
        .fhd_clk_o     (fhd_clk_o),
        .fhd_sdo_o     (fhd_sdo_o),
        .fhd_csn_o     (fhd_csn_o),
        .fhd_sdi_i     (fhd_sdi_i)
    );

    always #5 clk = ~clk;

    // DAC80504 receiver: shifts SDO on SCLK falls, commits on CS# rise after 24 falls.
    logic [23:0] rx_sh = '0;
    int          falls_cur = 0;
    int          last_falls = 0;
    int          min_int = 0;
    int          max_int = 0;
    longint      last_fall_t = -1;
    logic [15:0] vout [4];

    initial begin
        for (int i = 0; i < 4; i++) vout[i] = 16'h0000;
    end

    always @(negedge fhd_csn_o) begin
        falls_cur   = 0;
        min_int     = 1000000;
        max_int     = 0;
        last_fall_t = -1;
    end

    always @(negedge fhd_clk_o) begin
        if (fhd_csn_o === 1'b0) begin
            rx_sh = {rx_sh[22:0], fhd_sdo_o};
            falls_cur++;
            if (last_fall_t >= 0) begin
                int iv;
                iv = int'(($time - last_fall_t) / 10);
                if (iv < min_int) min_int = iv;
                if (iv > max_int) max_int = iv;
            end
            last_fall_t = $time;
        end
    end

    always @(posedge fhd_csn_o) begin
        last_falls = falls_cur;
        if (falls_cur == 24 && rx_sh[23:16] >= 8'h08 && rx_sh[23:16] <= 8'h0B)
            vout[rx_sh[17:16]] = rx_sh[15:0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy_o !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check("idle_timeout", 32'(busy_o), 32'h0);
    endtask

    // One-cycle request pulse; returns the number of cycles busy_o stayed high.
    task automatic send(input logic [31:0] d, input logic [5:0] div, output int busy_cycles);
        wait_idle();
        data_i        = d;
        spi_clk_div_i = div;
        valid_i       = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        busy_cycles = 0;
        while (busy_o === 1'b1 && busy_cycles < 5000) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int bc;
        int n;

        // Reset and idle levels
        repeat (3) @(negedge clk);
        check("rst_csn", 32'(fhd_csn_o), 32'h1);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_csn", 32'(fhd_csn_o), 32'h1);
        check("idle_sclk", 32'(fhd_clk_o), 32'h1);
        check("idle_sdo", 32'(fhd_sdo_o), 32'h0);
        check("idle_busy", 32'(busy_o), 32'h0);

        // Single frame at H=33
        send(32'h0008_1234, 6'd32, bc);
        check("h33_busy", 32'(bc), 32'd1683);
        check("h33_falls", 32'(last_falls), 32'd24);
        check("h33_min_period", 32'(min_int), 32'd66);
        check("h33_max_period", 32'(max_int), 32'd66);
        check("h33_vout0", 32'(vout[0]), 32'h1234);

        // Channels 1-3
        send(32'h0009_0002, 6'd3, bc);
        send(32'h020A_0003, 6'd3, bc);
        send(32'h030B_0004, 6'd3, bc);
        check("vout1", 32'(vout[1]), 32'h2);
        check("vout2", 32'(vout[2]), 32'h3);
        check("vout3", 32'(vout[3]), 32'h4);
        check("vout0_kept", 32'(vout[0]), 32'h1234);

        // Back-to-back with data change mid-frame, H=5
        wait_idle();
        spi_clk_div_i = 6'd4;
        data_i  = 32'h0008_0111;
        valid_i = 1'b1;
        repeat (20) @(negedge clk);
        data_i = 32'h0008_0222;
        n = 0;
        while (fhd_csn_o !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first", 32'(vout[0]), 32'h0111);
        n = 0;
        while (fhd_csn_o === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        valid_i = 1'b0;
        check("b2b_gap", 32'(n), 32'd11);
        wait_idle();
        check("b2b_second", 32'(vout[0]), 32'h0222);

        // Fastest rate, H=1
        send(32'h0008_ABCD, 6'd0, bc);
        check("h1_busy", 32'(bc), 32'd51);
        check("h1_falls", 32'(last_falls), 32'd24);
        check("h1_period", 32'(min_int), 32'd2);
        check("h1_vout0", 32'(vout[0]), 32'hABCD);

        // Reset asserted during bit 10
        wait_idle();
        spi_clk_div_i = 6'd3;
        data_i  = 32'h0008_0555;
        valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        n = 0;
        while (falls_cur < 11 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_bit10", 32'(falls_cur), 32'd11);
        rst_n = 1'b0;
        #1;
        check("abort_csn", 32'(fhd_csn_o), 32'h1);
        check("abort_sclk", 32'(fhd_clk_o), 32'h1);
        check("abort_sdo", 32'(fhd_sdo_o), 32'h0);
        check("abort_busy", 32'(busy_o), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("abort_vout0_kept", 32'(vout[0]), 32'hABCD);
        send(32'h0008_0777, 6'd3, bc);
        check("after_abort_busy", 32'(bc), 32'd204);
        check("after_abort_vout0", 32'(vout[0]), 32'h0777);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
